wb_check_monitor: RTL and testbench

WB_CHECK_MONITOR -- requirements
Module: wb_check_monitor

---
 rtl/wb_check_monitor.sv | 163 ++++++++++++++++
 tb/tb_wb_check_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_check_monitor.sv
// Writeback check monitor: shadows the DUT register file, runs for run_len cycles, then scans an
// expectation table one entry per cycle. Optional macro WB_CHECK_STOP_ON_FAIL_EN ends the scan early.
module wb_check_monitor #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NCHK   = 8,
  parameter int unsigned CW_CYC = 16,
  localparam int unsigned RW    = $clog2(NREG),
  localparam int unsigned CW    = $clog2(NCHK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_exp_we,
  input  logic [CW-1:0]     i_exp_idx,
  input  logic              i_exp_vld,
  input  logic [RW-1:0]     i_exp_reg,
  input  logic [XLEN-1:0]   i_exp_val,
  input  logic [CW_CYC-1:0] i_run_len,
  input  logic              i_start,
  input  logic              i_wb_en,
  input  logic [RW-1:0]     i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic [CW-1:0]     o_fail_idx,
  output logic [XLEN-1:0]   o_fail_got,
  output logic [CW:0]       o_err_cnt
);

  localparam int unsigned EW = CW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_shadow [NREG];
  logic [NCHK-1:0]   r_vld;
  logic [RW-1:0]     r_reg [NCHK];
  logic [XLEN-1:0]   r_val [NCHK];
  logic [CW_CYC-1:0] r_cnt;
  logic [CW-1:0]     r_idx;
  logic [EW-1:0]     r_err;
  logic [CW-1:0]     r_fail_idx;
  logic [XLEN-1:0]   r_fail_got;

  logic            w_idle_or_done;
  logic            w_start;
  logic            w_tbl_we;
  logic [RW-1:0]   w_cur_reg;
  logic [XLEN-1:0] w_got;
  logic            w_mis;
  logic            w_last;

  assign w_idle_or_done = (r_state == StIdle) || (r_state == StDone);
  assign w_start        = i_start && w_idle_or_done;
  assign w_tbl_we       = i_exp_we && w_idle_or_done;
  assign w_cur_reg      = r_reg[r_idx];
  assign w_last         = (r_idx == CW'(NCHK - 1));

  // Same-cycle writeback to the checked register is forwarded into the compare.
  assign w_got = (w_cur_reg == '0) ? '0 :
                 (i_wb_en && (i_wb_rd == w_cur_reg)) ? i_wb_data : r_shadow[w_cur_reg];
  assign w_mis = (r_state == StCheck) && r_vld[r_idx] && (w_got != r_val[r_idx]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_pass      = 1'b0;
    o_fail      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_nxt = StRun;
      end
      StRun: begin
        o_busy = 1'b1;
        if (r_cnt == '0) w_state_nxt = StCheck;
      end
      StCheck: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = StDone;
`ifdef WB_CHECK_STOP_ON_FAIL_EN
        if (w_mis) w_state_nxt = StDone;
`endif
      end
      StDone: begin
        o_done = 1'b1;
        o_pass = (r_err == '0);
        o_fail = (r_err != '0);
        if (w_start) w_state_nxt = StRun;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Shadow is frozen in DONE so the reported fail_got stays meaningful.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) r_shadow[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < int'(NREG); i++) r_shadow[i] <= '0;
    end else if (i_wb_en && (i_wb_rd != '0) && (r_state != StDone)) begin
      r_shadow[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (w_tbl_we) begin
      r_vld[i_exp_idx] <= i_exp_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tbl_we) begin
      r_reg[i_exp_idx] <= i_exp_reg;
      r_val[i_exp_idx] <= i_exp_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_err      <= '0;
      r_fail_idx <= '0;
      r_fail_got <= '0;
    end else if (w_start) begin
      r_cnt      <= i_run_len;
      r_idx      <= '0;
      r_err      <= '0;
      r_fail_idx <= '0;
      r_fail_got <= '0;
    end else begin
      if ((r_state == StRun) && (r_cnt != '0)) r_cnt <= r_cnt - CW_CYC'(1);
      if (r_state == StCheck) begin
        r_idx <= r_idx + CW'(1);
        if (w_mis) begin
          if (r_err != '1) r_err <= r_err + EW'(1);
          if (r_err == '0) begin
            r_fail_idx <= r_idx;
            r_fail_got <= w_got;
          end
        end
      end
    end
  end

  assign o_fail_idx = r_fail_idx;
  assign o_fail_got = r_fail_got;
  assign o_err_cnt  = r_err;

endmodule

// File: tb/tb_wb_check_monitor.sv
// Randomized bench for wb_check_monitor; the reference model replays writebacks per cycle and
// applies the expectation rules directly.
module tb_wb_check_monitor;

  localparam int NCHK = 8;
  localparam int MAXC = 128;
`ifdef WB_CHECK_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_idx = '0;
  logic        exp_vld = 1'b0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_val = '0;
  logic [15:0] run_len = '0;
  logic        start = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        busy, done, pass, fail;
  logic [2:0]  fail_idx;
  logic [31:0] fail_got;
  logic [3:0]  err_cnt;

  int n_vec = 0;
  int n_mis = 0;

  // Reference state: table contents, per-run shadow, writeback/table-write schedule.
  logic        m_vld [NCHK];
  logic [4:0]  m_reg [NCHK];
  logic [31:0] m_val [NCHK];
  logic [31:0] m_sh  [32];
  logic        s_en  [MAXC];
  logic [4:0]  s_rd  [MAXC];
  logic [31:0] s_data[MAXC];
  logic        s_we  [MAXC];
  logic [2:0]  g_we_idx;
  logic [4:0]  g_we_reg;
  logic [31:0] g_we_val;

  always #5 clk = ~clk;

  wb_check_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .i_exp_we   (exp_we),
    .i_exp_idx  (exp_idx),
    .i_exp_vld  (exp_vld),
    .i_exp_reg  (exp_reg),
    .i_exp_val  (exp_val),
    .i_run_len  (run_len),
    .i_start    (start),
    .i_wb_en    (wb_en),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_fail     (fail),
    .o_fail_idx (fail_idx),
    .o_fail_got (fail_got),
    .o_err_cnt  (err_cnt)
  );

  task automatic clear_sched();
    for (int n = 0; n < MAXC; n++) begin
      s_en[n] = 1'b0; s_rd[n] = '0; s_data[n] = '0; s_we[n] = 1'b0;
    end
  endtask

  task automatic add_wb(input int n, input logic [4:0] rd, input logic [31:0] d);
    s_en[n] = 1'b1; s_rd[n] = rd; s_data[n] = d;
  endtask

  task automatic write_entry(input int k, input logic v, input logic [4:0] r,
                             input logic [31:0] val);
    exp_we = 1'b1; exp_idx = 3'(k); exp_vld = v; exp_reg = r; exp_val = val;
    m_vld[k] = v; m_reg[k] = r; m_val[k] = val;
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int k = 0; k < NCHK; k++) write_entry(k, 1'b0, 5'd0, 32'd0);
  endtask

  // Starts a run in the current cycle and follows it to DONE, checking the outcome.
  task automatic do_run(input int len, input string name);
    int exp_err, first_idx, done_cyc, k;
    logic [31:0] first_got, got;
    bit stopped;
    for (int r = 0; r < 32; r++) m_sh[r] = '0;
    exp_err = 0; first_idx = 0; first_got = '0; stopped = 1'b0;
    done_cyc = len + 2 + NCHK;
    run_len = 16'(len);
    start = 1'b1;
    for (int n = 1; n <= len + 2 + NCHK; n++) begin
      @(negedge clk);
      start = 1'b0; exp_we = 1'b0; wb_en = 1'b0;
      if (n == done_cyc) begin
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_mis++;
          $display("FAIL %s done/busy: got %b/%b want 1/0", name, done, busy);
        end
        n_vec++;
        if (pass !== (exp_err == 0) || fail !== (exp_err != 0)) begin
          n_mis++;
          $display("FAIL %s pass/fail: got %b/%b want %b/%b", name, pass, fail,
                   exp_err == 0, exp_err != 0);
        end
        n_vec++;
        if (err_cnt !== 4'(exp_err)) begin
          n_mis++;
          $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, exp_err);
        end
        n_vec++;
        if (fail_idx !== 3'(first_idx) || fail_got !== first_got) begin
          n_mis++;
          $display("FAIL %s fail_idx/got: got %0d/%0d want %0d/%0d", name, fail_idx, fail_got,
                   first_idx, first_got);
        end
        break;
      end
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_mis++;
        $display("FAIL %s busy at cycle %0d: got busy=%b done=%b want 1/0", name, n, busy, done);
      end
      wb_en = s_en[n]; wb_rd = s_rd[n]; wb_data = s_data[n];
      if (s_we[n]) begin
        exp_we = 1'b1; exp_idx = g_we_idx; exp_vld = 1'b1; exp_reg = g_we_reg; exp_val = g_we_val;
      end
      k = n - len - 2;
      if (k >= 0 && k < NCHK && !stopped && m_vld[k]) begin
        if (m_reg[k] == 5'd0) got = '0;
        else if (wb_en && wb_rd == m_reg[k]) got = wb_data;
        else got = m_sh[m_reg[k]];
        if (got != m_val[k]) begin
          if (exp_err == 0) begin first_idx = k; first_got = got; end
          exp_err++;
          if (StopOnFail) begin stopped = 1'b1; done_cyc = n + 1; end
        end
      end
      if (wb_en && wb_rd != 5'd0) m_sh[wb_rd] = wb_data;
    end
    wb_en = 1'b0; exp_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, pass, fail} !== 4'b0 || err_cnt !== '0 || fail_idx !== '0 ||
        fail_got !== '0) begin
      n_mis++;
      $display("FAIL reset outputs: got b%b d%b p%b f%b e%0d i%0d g%0d want all 0",
               busy, done, pass, fail, err_cnt, fail_idx, fail_got);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL reset idle: got busy=%b done=%b want 0/0", busy, done);
    end
    for (int k = 0; k < NCHK; k++) m_vld[k] = 1'b0;
  endtask

  task automatic test_basic_pass();
    clear_sched();
    write_entry(0, 1'b1, 5'd2, 32'd120);
    add_wb(5, 5'd2, 32'd120);
    do_run(30, "basic_pass");
  endtask

  task automatic test_mismatch();
    clear_sched();
    add_wb(5, 5'd2, 32'd119);
    do_run(30, "mismatch");
  endtask

  task automatic test_x0();
    clear_table();
    clear_sched();
    write_entry(3, 1'b1, 5'd0, 32'd0);
    add_wb(2, 5'd0, 32'd5);
    do_run(4, "x0_zero");
  endtask

  task automatic test_multi();
    clear_table();
    clear_sched();
    write_entry(0, 1'b1, 5'd7, 32'd0);
    write_entry(1, 1'b1, 5'd3, 32'd10);
    write_entry(2, 1'b1, 5'd5, 32'd9);
    write_entry(4, 1'b1, 5'd4, 32'd20);
    add_wb(1, 5'd3, 32'd11);
    add_wb(2, 5'd4, 32'd21);
    add_wb(3, 5'd5, 32'd9);
    do_run(6, "multi_mismatch");
  endtask

  task automatic test_bypass();
    clear_table();
    clear_sched();
    write_entry(5, 1'b1, 5'd6, 32'd24);
    add_wb(2, 5'd6, 32'd1);
    add_wb(3 + 2 + 5, 5'd6, 32'd24);
    do_run(3, "bypass");
  endtask

  task automatic test_we_rules();
    clear_table();
    clear_sched();
    write_entry(0, 1'b1, 5'd2, 32'd50);
    add_wb(1, 5'd2, 32'd50);
    s_we[2] = 1'b1; g_we_idx = 3'd0; g_we_reg = 5'd2; g_we_val = 32'd99;
    do_run(5, "we_ignored_in_run");
    clear_sched();
    add_wb(1, 5'd9, 32'd7);
    exp_we = 1'b1; exp_idx = 3'd6; exp_vld = 1'b1; exp_reg = 5'd9; exp_val = 32'd8;
    m_vld[6] = 1'b1; m_reg[6] = 5'd9; m_val[6] = 32'd8;
    do_run(2, "we_with_start");
  endtask

  task automatic test_abort();
    clear_sched();
    write_entry(1, 1'b1, 5'd1, 32'd77);
    run_len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 + 1 + 3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, pass, fail} !== 4'b0 || err_cnt !== '0 || fail_idx !== '0 ||
        fail_got !== '0) begin
      n_mis++;
      $display("FAIL abort outputs: got b%b d%b p%b f%b e%0d want all 0",
               busy, done, pass, fail, err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NCHK; k++) m_vld[k] = 1'b0;
    @(negedge clk);
    do_run(4, "restart_after_abort");
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 12; it++) begin
      len = (it == 0) ? 0 : int'($urandom_range(0, 20));
      clear_sched();
      for (int n = 1; n <= len + 1 + NCHK; n++) begin
        if ($urandom_range(0, 1) == 1)
          add_wb(n, 5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
      end
      for (int k = 0; k < NCHK; k++)
        write_entry(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    32'($urandom_range(0, 3)));
      do_run(len, "random");
    end
  endtask

  initial begin
    clear_sched();
    g_we_idx = '0; g_we_reg = '0; g_we_val = '0;
    @(negedge clk);
    test_reset();
    test_basic_pass();
    test_mismatch();
    test_x0();
    test_multi();
    test_bypass();
    test_we_rules();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
